br_flow_demux_select: RTL
=========================

# br_flow_demux_select

Registered 1-to-N dataflow demultiplexer with an explicit binary select. It steers a single ready-valid push stream to one of `NumFlows` pop streams, and is the counterpart to the flow mux with select. Each pop flow has its own output register, so pop_valid and pop_data come directly from flops. The only combinational path is from select and pop_ready to push_ready. It sits wherever one producer fans out to several consumers under external routing control.

## Interface
- `NumFlows`, default 2: number of pop flows; must be >= 2.
- `Width`, default 1: payload width in bits; must be >= 1.
- `EnableCoverPushBackpressure`, default 1: if 1, cover push backpressure; if 0, assert push_ready is always 1 whenever push_valid is 1.
- `EnableAssertPushValidStability`, default `EnableCoverPushBackpressure`: assert push_valid is held while backpressured.
- `EnableAssertPushDataStability`, default `EnableAssertPushValidStability`: assert push_data is held while backpressured.
- `EnableAssertSelectStability`, default 0: assert select is held while push_valid && !push_ready.
- `EnableAssertFinalNotValid`, default 1: assert no pop_valid bit is set at end of test.
- `clk`, input, 1: single clock, rising edge.
- `rst`, input, 1: reset, asynchronous, active-high.
- `select`, input, `$clog2(NumFlows)`: target flow index for the current push.
- `push_ready`, output, 1: push-side ready.
- `push_valid`, input, 1: push-side valid.
- `push_data`, input, `Width`: push payload.
- `pop_ready`, input, `NumFlows`: per-flow consumer ready.
- `pop_valid`, output, `NumFlows`: per-flow valid; registered.
- `pop_data`, output, `NumFlows`x`Width`: per-flow payload; registered.

## Operation
- Per-flow state is one register stage: `valid_q[i]` and `data_q[i]`.
- Slot i can accept a new entry when `!valid_q[i] || pop_ready[i]`.
- push_ready = !rst && (select < NumFlows) && (slot[select] can accept).
- A push transfers when push_valid && push_ready.
  - On a transfer, `valid_q[select]` is set to 1 and `data_q[select]` is loaded with push_data.
- A pop on flow i transfers when pop_valid[i] && pop_ready[i].
  - If flow i pops with no new push to i in the same cycle, `valid_q[i]` clears to 0.
- Pop and push to the same flow in the same cycle: the slot reloads with the new data and `valid_q` stays 1. Full throughput per flow.
- Flows are independent. A stalled flow j does not block pushes to flow k ≠ j.
- At most one pop flow is loaded per cycle. Any number of flows may pop in the same cycle.
- Out-of-range select (non-power-of-2 NumFlows, select >= NumFlows) forces push_ready = 0. An assertion fires if push_valid is 1 with an out-of-range select.
- Integration assertions:
  - NumFlows >= 2 and Width >= 1.
  - push_valid, push_data, and select stability per the enable parameters.
  - push_data is known when push_valid is 1.
- Implementation assertions:
  - pop_valid[i] stays high until popped.
  - pop_data[i] is stable while pop_valid[i] && !pop_ready[i].
  - Final-not-valid check, per `EnableAssertFinalNotValid`.

## Timing
- Reset values: pop_valid = 0, pop_data = 0, push_ready = 0 while rst is high.
- Reset is asynchronous. Asserting rst mid-operation clears all `valid_q` immediately and drops any held entries. The first push is accepted on the first rising edge after rst deasserts.
- Latency: push accepted at edge N appears on pop_valid[select]/pop_data after edge N, i.e. visible in cycle N+1.
- push_ready is combinational from select, pop_ready[select], and `valid_q[select]`. Changing select within a cycle may change push_ready in that cycle.
- Throughput: 1 transfer/cycle total. Each flow sustains 1/cycle while its pop_ready is held at 1.

## Test plan
- Reset, then NumFlows=3, Width=8, select=2, push 0xA5 with pop_ready=3'b111:
  - Required: pop_valid=3'b100 and pop_data[2]=0xA5 one cycle later, then 0 the following cycle.
- Backpressure: pop_ready[1]=0, push 0x11 then 0x22 to flow 1:
  - Required: 0x11 is held on flow 1 and push_ready=0 for the second push.
  - Raise pop_ready[1]. Required: 0x11 pops and 0x22 is accepted in the same cycle, then appears next cycle.
- Independence: flow 0 full and stalled, push 0x33 with select=2:
  - Required: push_ready=1, and flow 2 shows 0x33 while flow 0 still holds its data.
- Streaming: select=0, pop_ready[0]=1, push 0x01..0x08 on consecutive cycles:
  - Required: pop_data[0] shows 0x01..0x08 on consecutive cycles with no bubbles.
- Out-of-range select: NumFlows=3, select=3, push_valid=1:
  - Required: push_ready=0, no pop_valid change, and the assertion fires.
- Async reset mid-stream: assert rst between edges while flows 0 and 2 are valid:
  - Required: pop_valid=0 immediately, before the next edge, and push_ready=0.
  - After release, a push to flow 0 of 0x7E appears one cycle later.

Source files
------------

// File: rtl/br_flow_demux_select.sv
// Registered 1-to-N ready/valid demultiplexer steered by an explicit binary select.
// Each pop flow owns one output register; push_ready is the only combinational output.
module br_flow_demux_select #(
    parameter int NumFlows = 2,
    parameter int Width = 1,
    parameter bit EnableCoverPushBackpressure = 1'b1,
    parameter bit EnableAssertPushValidStability = EnableCoverPushBackpressure,
    parameter bit EnableAssertPushDataStability = EnableAssertPushValidStability,
    parameter bit EnableAssertSelectStability = 1'b0,
    parameter bit EnableAssertFinalNotValid = 1'b1,
    parameter bit EnableAssertSelectInRange = 1'b1,
    localparam int SelWidth = (NumFlows > 1) ? $clog2(NumFlows) : 1
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [SelWidth-1:0]            select,
    output logic                           push_ready,
    input  logic                           push_valid,
    input  logic [Width-1:0]               push_data,
    input  logic [NumFlows-1:0]            pop_ready,
    output logic [NumFlows-1:0]            pop_valid,
    output logic [NumFlows-1:0][Width-1:0] pop_data
);

    logic [NumFlows-1:0]            valid_q;
    logic [NumFlows-1:0]            valid_d;
    logic [NumFlows-1:0][Width-1:0] data_q;
    logic [NumFlows-1:0][Width-1:0] data_d;
    logic [NumFlows-1:0]            slot_free_s;
    logic [NumFlows-1:0]            load_s;
    logic                           select_in_range_s;
    logic                           select_free_s;
    logic                           push_xfer_s;

    // Decode select: a slot accepts when empty or draining this cycle; an unmatched select blocks the push.
    always_comb begin
        select_in_range_s = 1'b0;
        select_free_s     = 1'b0;
        slot_free_s       = {NumFlows{1'b0}};
        for (int i = 0; i < NumFlows; i++) begin
            slot_free_s[i]    = !valid_q[i] || pop_ready[i];
            select_in_range_s = select_in_range_s || (select == SelWidth'(i));
            select_free_s     = select_free_s || ((select == SelWidth'(i)) && slot_free_s[i]);
        end
        push_ready  = !rst && select_in_range_s && select_free_s;
        push_xfer_s = push_valid && push_ready;
    end

    // Per-flow next state: a load wins over a pop so a flow can reload every cycle.
    always_comb begin
        valid_d = valid_q;
        data_d  = data_q;
        load_s  = {NumFlows{1'b0}};
        for (int i = 0; i < NumFlows; i++) begin
            load_s[i] = push_xfer_s && (select == SelWidth'(i));
            if (load_s[i]) begin
                valid_d[i] = 1'b1;
                data_d[i]  = push_data;
            end else if (pop_ready[i]) begin
                valid_d[i] = 1'b0;
            end else begin
                valid_d[i] = valid_q[i];
            end
        end
    end

    // Output register bank, cleared asynchronously so held entries drop at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= {NumFlows{1'b0}};
            data_q  <= {(NumFlows * Width){1'b0}};
        end else begin
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end

    assign pop_valid = valid_q;
    assign pop_data  = data_q;

    br_flow_demux_select_chk #(
        .NumFlows                       (NumFlows),
        .Width                          (Width),
        .SelWidth                       (SelWidth),
        .EnableCoverPushBackpressure    (EnableCoverPushBackpressure),
        .EnableAssertPushValidStability (EnableAssertPushValidStability),
        .EnableAssertPushDataStability  (EnableAssertPushDataStability),
        .EnableAssertSelectStability    (EnableAssertSelectStability),
        .EnableAssertFinalNotValid      (EnableAssertFinalNotValid),
        .EnableAssertSelectInRange      (EnableAssertSelectInRange)
    ) u_chk (
        .clk             (clk),
        .rst             (rst),
        .select          (select),
        .select_in_range (select_in_range_s),
        .push_ready      (push_ready),
        .push_valid      (push_valid),
        .push_data       (push_data),
        .pop_ready       (pop_ready),
        .pop_valid       (pop_valid),
        .pop_data        (pop_data)
    );

endmodule

// Protocol checker for br_flow_demux_select: integration and implementation properties.
module br_flow_demux_select_chk #(
    parameter int NumFlows = 2,
    parameter int Width = 1,
    parameter int SelWidth = 1,
    parameter bit EnableCoverPushBackpressure = 1'b1,
    parameter bit EnableAssertPushValidStability = 1'b1,
    parameter bit EnableAssertPushDataStability = 1'b1,
    parameter bit EnableAssertSelectStability = 1'b0,
    parameter bit EnableAssertFinalNotValid = 1'b1,
    parameter bit EnableAssertSelectInRange = 1'b1
) (
    input logic                           clk,
    input logic                           rst,
    input logic [SelWidth-1:0]            select,
    input logic                           select_in_range,
    input logic                           push_ready,
    input logic                           push_valid,
    input logic [Width-1:0]               push_data,
    input logic [NumFlows-1:0]            pop_ready,
    input logic [NumFlows-1:0]            pop_valid,
    input logic [NumFlows-1:0][Width-1:0] pop_data
);

    logic stalled_s;

    // A push held off only by a bad select is a usage error, not backpressure, so it is excluded here.
    assign stalled_s = push_valid && !push_ready && select_in_range;

    a_params: assert property (@(posedge clk) (NumFlows >= 2) && (Width >= 1));

    a_no_backpressure: assert property (@(posedge clk) disable iff (rst)
        (!EnableCoverPushBackpressure && push_valid) |-> push_ready);
    c_backpressure: cover property (@(posedge clk) disable iff (rst)
        EnableCoverPushBackpressure && push_valid && !push_ready);

    a_valid_stable: assert property (@(posedge clk) disable iff (rst)
        (EnableAssertPushValidStability && stalled_s) |=> push_valid);
    a_data_stable: assert property (@(posedge clk) disable iff (rst)
        (EnableAssertPushDataStability && stalled_s) |=> $stable(push_data));
    a_select_stable: assert property (@(posedge clk) disable iff (rst)
        (EnableAssertSelectStability && stalled_s) |=> $stable(select));

    a_select_range: assert property (@(posedge clk) disable iff (rst)
        (EnableAssertSelectInRange && push_valid) |-> select_in_range);
    a_data_known: assert property (@(posedge clk) disable iff (rst)
        push_valid |-> !$isunknown(push_data));

    for (genvar i = 0; i < NumFlows; i++) begin : g_flow
        a_pop_hold: assert property (@(posedge clk) disable iff (rst)
            (pop_valid[i] && !pop_ready[i]) |=> pop_valid[i]);
        a_pop_data_stable: assert property (@(posedge clk) disable iff (rst)
            (pop_valid[i] && !pop_ready[i]) |=> $stable(pop_data[i]));
    end

    final begin
        if (EnableAssertFinalNotValid) begin
            a_final_not_valid: assert (pop_valid == {NumFlows{1'b0}});
        end
    end

endmodule
